// File: rtl/fe_fetch_addr_gen.sv
// Fetch address generator: issues line-aligned I-cache requests, buffers returned lines
// for decode, and restarts fetch on writeback EIP redirects.
module fe_fetch_addr_gen #(
   parameter logic [31:0] RESET_EIP = 32'hFFFF_FFF0,
   parameter int          DEPTH     = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_redirect_v,
   input  logic [31:0]  i_redirect_eip,
   output logic         o_ic_req,
   output logic [31:0]  o_ic_addr,
   input  logic         i_ic_ack,
   input  logic         i_ic_rdata_v,
   input  logic [127:0] i_ic_rdata,
   output logic         o_fe_line_v,
   output logic [127:0] o_fe_line,
   output logic [31:0]  o_fe_line_addr,
   output logic [3:0]   o_fe_start_off,
   input  logic         i_de_pop
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t         r_state, w_state_nx;
   logic [31:0]    r_fetch_addr, w_fetch_nx;
   logic [3:0]     r_pend_off, w_pend_nx;
   logic           r_ic_req;
   logic [31:0]    r_ic_addr;
   logic [PW-1:0]  r_head, r_tail, w_head_nx, w_tail_nx;
   logic [CW-1:0]  r_count, w_count_np, w_count_nx;
   logic [127:0]   r_mem_line [DEPTH];
   logic [31:0]    r_mem_addr [DEPTH];
   logic [3:0]     r_mem_off  [DEPTH];
   logic           r_fe_line_v;
   logic [127:0]   r_fe_line, w_nh_line;
   logic [31:0]    r_fe_line_addr, w_nh_addr;
   logic [3:0]     r_fe_start_off, w_nh_off;
   logic           w_push, w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A redirect squashes both the same-cycle pop and the same-cycle data return.
   assign w_pop      = i_de_pop && r_fe_line_v && !i_redirect_v;
   assign w_push     = (r_state == WAIT) && i_ic_rdata_v && !i_redirect_v;
   assign w_count_np = r_count + CW'(w_push) - CW'(w_pop);

   always_comb begin
      w_state_nx = r_state;
      w_fetch_nx = r_fetch_addr;
      w_pend_nx  = r_pend_off;
      w_head_nx  = w_pop  ? ptr_inc(r_head) : r_head;
      w_tail_nx  = w_push ? ptr_inc(r_tail) : r_tail;
      w_count_nx = w_count_np;
      if (i_redirect_v) begin
         w_fetch_nx = {i_redirect_eip[31:4], 4'h0};
         w_pend_nx  = i_redirect_eip[3:0];
         w_head_nx  = '0;
         w_tail_nx  = '0;
         w_count_nx = '0;
         if ((r_state == WAIT && !i_ic_rdata_v) || (r_state == REQ && i_ic_ack) ||
             r_state == DROP)
            w_state_nx = DROP;
         else
            w_state_nx = REQ;
      end else begin
         case (r_state)
            IDLE: if (r_count < CW'(DEPTH)) w_state_nx = REQ;
            REQ: if (i_ic_ack) begin
               w_state_nx = WAIT;
               w_fetch_nx = r_fetch_addr + 32'd16;
            end
            WAIT: if (i_ic_rdata_v) begin
               w_pend_nx  = 4'h0;
               w_state_nx = (w_count_np < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: if (i_ic_rdata_v) w_state_nx = REQ;
            default: w_state_nx = IDLE;
         endcase
      end
   end

   // Next head entry, bypassing the line being written when it lands at the new head.
   always_comb begin
      w_nh_line = r_mem_line[w_head_nx];
      w_nh_addr = r_mem_addr[w_head_nx];
      w_nh_off  = r_mem_off[w_head_nx];
      if (w_push && r_tail == w_head_nx) begin
         w_nh_line = i_ic_rdata;
         w_nh_addr = r_ic_addr;
         w_nh_off  = r_pend_off;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_fetch_addr   <= {RESET_EIP[31:4], 4'h0};
         r_pend_off     <= RESET_EIP[3:0];
         r_ic_req       <= 1'b0;
         r_ic_addr      <= '0;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_fe_line_v    <= 1'b0;
         r_fe_line      <= '0;
         r_fe_line_addr <= '0;
         r_fe_start_off <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_fetch_addr <= w_fetch_nx;
         r_pend_off   <= w_pend_nx;
         r_ic_req     <= (w_state_nx == REQ);
         if (w_state_nx == REQ) r_ic_addr <= w_fetch_nx;
         r_head       <= w_head_nx;
         r_tail       <= w_tail_nx;
         r_count      <= w_count_nx;
         r_fe_line_v  <= (w_count_nx != '0);
         if (w_count_nx != '0) begin
            r_fe_line      <= w_nh_line;
            r_fe_line_addr <= w_nh_addr;
            r_fe_start_off <= w_nh_off;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_line[r_tail] <= i_ic_rdata;
         r_mem_addr[r_tail] <= r_ic_addr;
         r_mem_off[r_tail]  <= r_pend_off;
      end
   end

   assign o_ic_req       = r_ic_req;
   assign o_ic_addr      = r_ic_addr;
   assign o_fe_line_v    = r_fe_line_v;
   assign o_fe_line      = r_fe_line;
   assign o_fe_line_addr = r_fe_line_addr;
   assign o_fe_start_off = r_fe_start_off;

endmodule

// File: tb/tb_fe_fetch_addr_gen.sv
// Directed bench for fe_fetch_addr_gen: reset, wrap, fill/backpressure, redirect cases, async reset.
module tb_fe_fetch_addr_gen;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         i_redirect_v = 1'b0;
   logic [31:0]  i_redirect_eip = '0;
   logic         o_ic_req;
   logic [31:0]  o_ic_addr;
   logic         i_ic_ack = 1'b0;
   logic         i_ic_rdata_v = 1'b0;
   logic [127:0] i_ic_rdata = '0;
   logic         o_fe_line_v;
   logic [127:0] o_fe_line;
   logic [31:0]  o_fe_line_addr;
   logic [3:0]   o_fe_start_off;
   logic         i_de_pop = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [127:0] D1 = 128'h1111_0000_1111_0000_1111_0000_1111_0001;
   localparam logic [127:0] D2 = 128'h2222_0000_2222_0000_2222_0000_2222_0002;
   localparam logic [127:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
   localparam logic [127:0] D4 = 128'h4444_0000_4444_0000_4444_0000_4444_0004;
   localparam logic [127:0] D5 = 128'h5555_0000_5555_0000_5555_0000_5555_0005;
   localparam logic [127:0] D6 = 128'h6666_0000_6666_0000_6666_0000_6666_0006;
   localparam logic [127:0] D7 = 128'h7777_0000_7777_0000_7777_0000_7777_0007;

   fe_fetch_addr_gen #(.RESET_EIP(32'hFFFF_FFF3), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_redirect_v   (i_redirect_v),
      .i_redirect_eip (i_redirect_eip),
      .o_ic_req       (o_ic_req),
      .o_ic_addr      (o_ic_addr),
      .i_ic_ack       (i_ic_ack),
      .i_ic_rdata_v   (i_ic_rdata_v),
      .i_ic_rdata     (i_ic_rdata),
      .o_fe_line_v    (o_fe_line_v),
      .o_fe_line      (o_fe_line),
      .o_fe_line_addr (o_fe_line_addr),
      .o_fe_start_off (o_fe_start_off),
      .i_de_pop       (i_de_pop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Async reset assertion, checked while clock runs
      #2 rst_n = 1'b0;
      tick(); tick();
      chk("rst_req",   128'(o_ic_req), 128'h0);
      chk("rst_addr",  128'(o_ic_addr), 128'h0);
      chk("rst_v",     128'(o_fe_line_v), 128'h0);
      chk("rst_line",  o_fe_line, 128'h0);
      chk("rst_laddr", 128'(o_fe_line_addr), 128'h0);
      chk("rst_off",   128'(o_fe_start_off), 128'h0);
      rst_n = 1'b1;

      // 1: first request at reset line, start offset 3, wrap to 0
      tick();
      chk("t1_req",  128'(o_ic_req), 128'h1);
      chk("t1_addr", 128'(o_ic_addr), 128'hFFFF_FFF0);
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      chk("t1_req_off", 128'(o_ic_req), 128'h0);
      i_ic_rdata_v = 1'b1; i_ic_rdata = D1;
      tick();
      i_ic_rdata_v = 1'b0;
      chk("t1_v",     128'(o_fe_line_v), 128'h1);
      chk("t1_line",  o_fe_line, D1);
      chk("t1_laddr", 128'(o_fe_line_addr), 128'hFFFF_FFF0);
      chk("t1_off",   128'(o_fe_start_off), 128'h3);
      chk("t1_wreq",  128'(o_ic_req), 128'h1);
      chk("t1_wrap",  128'(o_ic_addr), 128'h0);

      // 2: fill to DEPTH without pops, then one pop reopens fetch
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      i_ic_rdata_v = 1'b1; i_ic_rdata = D2;
      tick();
      i_ic_rdata_v = 1'b0;
      chk("t2_full_req", 128'(o_ic_req), 128'h0);
      chk("t2_head",     o_fe_line, D1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_idle_req", 128'(o_ic_req), 128'h0);
      end
      i_de_pop = 1'b1;
      tick();
      i_de_pop = 1'b0;
      chk("t2_pop_line",  o_fe_line, D2);
      chk("t2_pop_laddr", 128'(o_fe_line_addr), 128'h0);
      chk("t2_pop_off",   128'(o_fe_start_off), 128'h0);
      tick();
      chk("t2_rereq",  128'(o_ic_req), 128'h1);
      chk("t2_readdr", 128'(o_ic_addr), 128'h10);

      // 3: redirect while WAIT drops buffer and the stale return
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      i_redirect_v = 1'b1; i_redirect_eip = 32'h1234_5678;
      tick();
      i_redirect_v = 1'b0;
      chk("t3_empty", 128'(o_fe_line_v), 128'h0);
      chk("t3_noreq", 128'(o_ic_req), 128'h0);
      tick();
      chk("t3_drop_req", 128'(o_ic_req), 128'h0);
      i_ic_rdata_v = 1'b1; i_ic_rdata = D3;
      tick();
      i_ic_rdata_v = 1'b0;
      chk("t3_stale_v", 128'(o_fe_line_v), 128'h0);
      chk("t3_req",     128'(o_ic_req), 128'h1);
      chk("t3_addr",    128'(o_ic_addr), 128'h1234_5670);
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      i_ic_rdata_v = 1'b1; i_ic_rdata = D4;
      tick();
      i_ic_rdata_v = 1'b0;
      chk("t3_line",  o_fe_line, D4);
      chk("t3_laddr", 128'(o_fe_line_addr), 128'h1234_5670);
      chk("t3_off",   128'(o_fe_start_off), 128'h8);
      chk("t3_next",  128'(o_ic_addr), 128'h1234_5680);

      // 4: redirect with same-cycle data and pop: no push, no DROP
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      i_ic_rdata_v = 1'b1; i_ic_rdata = D5; i_de_pop = 1'b1;
      i_redirect_v = 1'b1; i_redirect_eip = 32'hABCD_EF12;
      tick();
      i_ic_rdata_v = 1'b0; i_de_pop = 1'b0; i_redirect_v = 1'b0;
      chk("t4_v",    128'(o_fe_line_v), 128'h0);
      chk("t4_req",  128'(o_ic_req), 128'h1);
      chk("t4_addr", 128'(o_ic_addr), 128'hABCD_EF10);

      // 5: redirect with same-cycle ack: one stale line discarded
      i_ic_ack = 1'b1; i_redirect_v = 1'b1; i_redirect_eip = 32'h0000_1004;
      tick();
      i_ic_ack = 1'b0; i_redirect_v = 1'b0;
      chk("t5_noreq", 128'(o_ic_req), 128'h0);
      i_ic_rdata_v = 1'b1; i_ic_rdata = D6;
      tick();
      i_ic_rdata_v = 1'b0;
      chk("t5_stale_v", 128'(o_fe_line_v), 128'h0);
      chk("t5_req",     128'(o_ic_req), 128'h1);
      chk("t5_addr",    128'(o_ic_addr), 128'h1000);
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      i_ic_rdata_v = 1'b1; i_ic_rdata = D7;
      tick();
      i_ic_rdata_v = 1'b0;
      chk("t5_line", o_fe_line, D7);
      chk("t5_off",  128'(o_fe_start_off), 128'h4);

      // 6: async reset mid-WAIT with buffered data
      i_ic_ack = 1'b1;
      tick();
      i_ic_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req",   128'(o_ic_req), 128'h0);
      chk("t6_addr",  128'(o_ic_addr), 128'h0);
      chk("t6_v",     128'(o_fe_line_v), 128'h0);
      chk("t6_line",  o_fe_line, 128'h0);
      chk("t6_laddr", 128'(o_fe_line_addr), 128'h0);
      chk("t6_off",   128'(o_fe_start_off), 128'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_restart", 128'(o_ic_addr), 128'hFFFF_FFF0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
